// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller with built-in baud timing.
// Synchronises the serial line, qualifies the start bit at mid-bit, samples
// eight data bits LSB first, then checks the stop bit. A good byte is
// reported with a one-cycle done pulse; a low stop bit gives a one-cycle
// framing-error pulse and the receiver waits for the line to go idle again.
module uart_rx_ctrl #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en_sig,
  input  logic       rx_pin_in,
  output logic [7:0] rx_data,
  output logic       rx_done_sig,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int BIT_CNT = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            sync_p0;
  logic            sync_p1;
  logic            prev_p2;
  logic            line;
  logic            fall;

  logic [CW-1:0]   baud_cnt;
  logic [CW-1:0]   baud_last;
  logic            counting;
  logic            sample;

  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;

  logic            done_nxt;
  logic            ferr_nxt;

  // Synchroniser and edge register; all idle-high so reset looks like an idle line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= rx_pin_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign line = sync_p1;
  assign fall = prev_p2 & ~sync_p1;

  // Sample strobe: start bit uses the half-bit limit to land mid-bit, then full bits
  always_comb begin
    counting  = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    baud_last = (state == S_START) ? HALF_LAST : BIT_LAST;
    sample    = counting && (baud_cnt == baud_last);
  end

  // Next-state and pulse decode; disable overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_en_sig && fall) state_nxt = S_START;
      end
      S_START: begin
        if (sample) state_nxt = line ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample && (bit_idx == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (sample) begin
          if (line) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_BREAK;
            ferr_nxt  = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (line) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!rx_en_sig && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Baud counter: restarts on every state change and after each sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (state_nxt != state) begin
      baud_cnt <= '0;
    end else if (sample) begin
      baud_cnt <= '0;
    end else if (counting) begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Bit index: zeroed on entry to DATA, advanced on each data sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= 3'd0;
    end else if ((state != S_DATA) && (state_nxt == S_DATA)) begin
      bit_idx <= 3'd0;
    end else if ((state == S_DATA) && sample) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Shift register is pure data; a partial byte is never exposed so it needs no reset
  always_ff @(posedge clk) begin
    if ((state == S_DATA) && sample) shift_reg[bit_idx] <= line;
  end

  // Registered outputs: byte is committed only on a good stop bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= 8'h00;
      rx_done_sig  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done_sig  <= done_nxt;
      rx_frame_err <= ferr_nxt;
      if (done_nxt) rx_data <= shift_reg;
    end
  end

  assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at BIT_CNT=16, HALF=8.
module tb_uart_rx_ctrl;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BITN   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en_sig = 1'b0;
  logic       rx_pin_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done_sig;
  logic       rx_frame_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  int cyc_no = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  logic [7:0] done_data [0:31];
  int         done_cyc  [0:31];
  logic       done_prev = 1'b0;
  logic       ferr_prev = 1'b0;
  int last_start = 0;

  uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_en_sig    (rx_en_sig),
    .rx_pin_in    (rx_pin_in),
    .rx_data      (rx_data),
    .rx_done_sig  (rx_done_sig),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rx_done_sig) begin
      if (done_cnt < 32) begin
        done_data[done_cnt] = rx_data;
        done_cyc[done_cnt]  = cyc_no;
      end
      done_cnt++;
    end
    if (rx_frame_err) ferr_cnt++;
    if (rx_done_sig && rx_frame_err) both_cnt++;
    if ((rx_done_sig && done_prev) || (rx_frame_err && ferr_prev)) wide_cnt++;
    done_prev = rx_done_sig;
    ferr_prev = rx_frame_err;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    last_start = cyc_no;
    rx_pin_in = 1'b0;
    cyc(BITN);
    for (int i = 0; i < 8; i++) begin
      rx_pin_in = d[i];
      cyc(BITN);
    end
    rx_pin_in = stop_bit;
    cyc(BITN);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
    total++; if (rx_done_sig !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", rx_done_sig); end
    total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", rx_frame_err); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", rx_busy); end
    rst = 1'b0;
    rx_en_sig = 1'b1;
    cyc(5);
  endtask

  task automatic test_single;
    int d0;
    int lat;
    d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    cyc(20);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL single_count got=%0d want=%0d", done_cnt - d0, 1); end
    total++; if (done_data[d0] !== 8'hA5) begin bad++; $display("FAIL single_pulse_data got=%h want=a5", done_data[d0]); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", rx_data); end
    total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL single_ferr got=%0d want=0", ferr_cnt); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", rx_busy); end
    lat = done_cyc[d0] - last_start;
    total++; if (lat < 154 || lat > 156) begin bad++; $display("FAIL single_latency got=%0d want=155", lat); end
  endtask

  task automatic test_back_to_back;
    int d0;
    int gap;
    d0 = done_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    cyc(20);
    total++; if (done_cnt !== d0 + 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", done_cnt - d0); end
    total++; if (done_data[d0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", done_data[d0]); end
    total++; if (done_data[d0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", done_data[d0+1]); end
    gap = done_cyc[d0+1] - done_cyc[d0];
    total++; if (gap !== 160) begin bad++; $display("FAIL b2b_gap got=%0d want=160", gap); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL b2b_data got=%h want=ff", rx_data); end
  endtask

  task automatic test_glitch;
    int d0;
    int f0;
    int busy_n;
    d0 = done_cnt;
    f0 = ferr_cnt;
    busy_n = 0;
    rx_pin_in = 1'b0;
    cyc(3);
    rx_pin_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_busy) busy_n++;
    end
    cyc(2);
    total++; if (busy_n < 7 || busy_n > 10) begin bad++; $display("FAIL glitch_busy_len got=%0d want=8", busy_n); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", rx_busy); end
    total++; if (done_cnt !== d0 || ferr_cnt !== f0) begin bad++; $display("FAIL glitch_pulses got=%0d/%0d want=0/0", done_cnt - d0, ferr_cnt - f0); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL glitch_data got=%h want=ff", rx_data); end
  endtask

  task automatic test_frame_err;
    int d0;
    int f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    cyc(40);
    total++; if (ferr_cnt !== f0 + 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", ferr_cnt - f0); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL ferr_no_done got=%0d want=0", done_cnt - d0); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL ferr_data_kept got=%h want=ff", rx_data); end
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_held got=%b want=1", rx_busy); end
    rx_pin_in = 1'b1;
    cyc(4);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release got=%b want=0", rx_busy); end
    cyc(4);
    send_byte(8'h81, 1'b1);
    cyc(20);
    total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL ferr_recover got=%h want=81", rx_data); end
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL ferr_recover_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_abort;
    int d0;
    int f0;
    logic [7:0] b;
    d0 = done_cnt;
    f0 = ferr_cnt;
    b = 8'h77;
    rx_pin_in = 1'b0;
    cyc(BITN);
    for (int i = 0; i < 4; i++) begin
      rx_pin_in = b[i];
      cyc(BITN);
    end
    rx_pin_in = b[4];
    cyc(BITN / 2);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", rx_busy); end
    rx_en_sig = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b want=0", rx_busy); end
    #1;
    cyc(BITN / 2);
    for (int i = 5; i < 8; i++) begin
      rx_pin_in = b[i];
      cyc(BITN);
    end
    rx_pin_in = 1'b1;
    cyc(2 * BITN);
    total++; if (done_cnt !== d0 || ferr_cnt !== f0) begin bad++; $display("FAIL abort_pulses got=%0d/%0d want=0/0", done_cnt - d0, ferr_cnt - f0); end
    total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL abort_data_kept got=%h want=81", rx_data); end
    rx_en_sig = 1'b1;
    cyc(4);
    send_byte(8'h5A, 1'b1);
    cyc(20);
    total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL abort_recover got=%h want=5a", rx_data); end
  endtask

  task automatic test_midframe_reset;
    int d0;
    logic [7:0] b;
    b = 8'h96;
    rx_pin_in = 1'b0;
    cyc(BITN);
    for (int i = 0; i < 2; i++) begin
      rx_pin_in = b[i];
      cyc(BITN);
    end
    rx_pin_in = b[2];
    cyc(BITN / 2);
    rst = 1'b1;
    #2;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_async_data got=%h want=00", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", rx_busy); end
    total++; if (rx_done_sig !== 1'b0 || rx_frame_err !== 1'b0) begin bad++; $display("FAIL rst_async_pulses got=%b%b want=00", rx_done_sig, rx_frame_err); end
    cyc(BITN / 2);
    for (int i = 3; i < 8; i++) begin
      rx_pin_in = b[i];
      cyc(BITN);
    end
    rx_pin_in = 1'b1;
    cyc(BITN);
    d0 = done_cnt;
    rst = 1'b0;
    cyc(4);
    send_byte(8'hC3, 1'b1);
    cyc(20);
    total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL rst_recover got=%h want=c3", rx_data); end
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL rst_recover_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_pulse_shape;
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d want=0", both_cnt); end
    total++; if (wide_cnt !== 0) begin bad++; $display("FAIL pulse_width got=%0d want=0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_abort();
    test_midframe_reset();
    test_pulse_shape();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
